load_store_unit: RTL and testbench

Load/store unit for the RV32I core, between the execute stage and the register file write port. It accepts one memory instruction at a time, forms the effective address, and drives a simple request/acknowledge data-memory port with byte strobes. It sign- or zero-extends load data and presents it as a one-cycle register-file write (`wb_en`/`wb_rd`/`wb_data`). Misaligned accesses and illegal funct3 encodings are reported as exceptions and issue no memory request.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute-stage request, data-memory port and write-back bundle for the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    modport slave (
        input  req_valid, is_load, is_store, funct3, base, offset, store_data, rd_in,
        input  mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output wb_en, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );

    modport master (
        output req_valid, is_load, is_store, funct3, base, offset, store_data, rd_in,
        output mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  wb_en, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: address generation, lane steering, load extension, exceptions
module load_store_unit (
    input  logic clk,
    input  logic rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEM, WB, EXC} state_t;

    state_t      state, state_nxt;
    logic [31:0] ea;
    logic        accept, illegal, misaligned, exc_hit;
    logic [1:0]  cause_c;
    logic [31:0] wdata_c;
    logic [3:0]  wstrb_c;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  ea_lo_q;
    logic [31:0] byte_sel, half_sel, load_ext;
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q, exc_addr_q;
    logic [3:0]  mem_wstrb_q;
    logic [4:0]  wb_rd_q;
    logic [1:0]  exc_cause_q;
    logic        req_ready_c, mem_req_c, wb_en_c, exc_valid_c;

    assign ea     = bus.base + bus.offset;
    assign accept = bus.req_valid && (state == IDLE) && (bus.is_load || bus.is_store);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        wdata_c    = bus.store_data;
        wstrb_c    = 4'b1111;
        if (bus.is_load && bus.is_store)
            illegal = 1'b1;
        else if (bus.is_load)
            illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
        case (bus.funct3[1:0])
            2'b00: begin
                wdata_c = {4{bus.store_data[7:0]}};
                wstrb_c = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                misaligned = ea[0];
                wdata_c    = {2{bus.store_data[15:0]}};
                wstrb_c    = ea[1] ? 4'b1100 : 4'b0011;
            end
            2'b10:   misaligned = (ea[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (bus.is_load)
            wstrb_c = 4'b0000;
        exc_hit = illegal || misaligned;
        cause_c = illegal ? 2'b11 : (bus.is_load ? 2'b01 : 2'b10);
    end

    // Lane extraction uses the byte offset captured at accept, not the live request.
    assign byte_sel = bus.mem_rdata >> {ea_lo_q, 3'b000};
    assign half_sel = bus.mem_rdata >> {ea_lo_q[1], 4'b0000};

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel[15:0]};
            3'b100:  load_ext = {24'd0, byte_sel[7:0]};
            3'b101:  load_ext = {16'd0, half_sel[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = exc_hit ? EXC : MEM;
            MEM:     if (bus.mem_ack) state_nxt = ld_q ? WB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = (state == IDLE);
        mem_req_c   = (state == MEM);
        wb_en_c     = (state == WB) && (wb_rd_q != 5'd0);
        exc_valid_c = (state == EXC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_q        <= 1'b0;
            f3_q        <= 3'd0;
            ea_lo_q     <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= 32'd0;
        end else begin
            if (accept) begin
                ld_q    <= bus.is_load;
                f3_q    <= bus.funct3;
                ea_lo_q <= ea[1:0];
                if (exc_hit) begin
                    exc_cause_q <= cause_c;
                    exc_addr_q  <= ea;
                end else begin
                    mem_we_q    <= bus.is_store;
                    mem_addr_q  <= {ea[31:2], 2'b00};
                    mem_wdata_q <= wdata_c;
                    mem_wstrb_q <= wstrb_c;
                    wb_rd_q     <= bus.rd_in;
                end
            end
            if ((state == MEM) && bus.mem_ack && ld_q)
                wb_data_q <= load_ext;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.wb_en     = wb_en_c;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.exc_valid = exc_valid_c;
    assign bus.exc_cause = exc_cause_q;
    assign bus.exc_addr  = exc_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed and random traffic
module tb_load_store_unit;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
    typedef struct { logic [1:0] cause; logic [31:0] addr; } exc_exp_t;
    typedef struct { int delay; logic [31:0] rdata; } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic resp_ack = 1'b0;
    logic force_ack = 1'b0;
    logic [31:0] resp_rdata = 32'd0;
    int total = 0;
    int bad = 0;

    mem_exp_t mem_q[$];
    wb_exp_t  wb_q[$];
    exc_exp_t exc_q[$];
    resp_t    resp_q[$];

    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.mem_ack   = resp_ack | force_ack;
    assign bus.mem_rdata = resp_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got pulse want none", name);
    endtask

    // Monitor: compares every presented output against the front of its queue.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (mem_q.size() == 0) unexpected("mem_req");
            else begin
                check("mem_addr", bus.mem_addr, mem_q[0].addr);
                check("mem_we", 32'(bus.mem_we), 32'(mem_q[0].we));
                check("mem_wstrb", 32'(bus.mem_wstrb), 32'(mem_q[0].strb));
                if (mem_q[0].we) check("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
                if (bus.mem_ack) void'(mem_q.pop_front());
            end
        end
        if (bus.wb_en) begin
            if (wb_q.size() == 0) unexpected("wb_en");
            else begin
                check("wb_rd", 32'(bus.wb_rd), 32'(wb_q[0].rd));
                check("wb_data", bus.wb_data, wb_q[0].data);
                void'(wb_q.pop_front());
            end
        end
        if (bus.exc_valid) begin
            if (exc_q.size() == 0) unexpected("exc_valid");
            else begin
                check("exc_cause", 32'(bus.exc_cause), 32'(exc_q[0].cause));
                check("exc_addr", bus.exc_addr, exc_q[0].addr);
                void'(exc_q.pop_front());
            end
        end
    end

    // Memory responder: acks after the queued number of wait cycles.
    initial begin
        int cnt;
        logic active;
        resp_t r;
        active = 1'b0;
        cnt = 0;
        r = '{0, 32'd0};
        forever begin
            @(posedge clk); #1;
            resp_ack = 1'b0;
            if (!bus.mem_req) active = 1'b0;
            else begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (resp_q.size() > 0) r = resp_q.pop_front();
                    else r = '{0, 32'd0};
                end
                if (cnt == r.delay) begin
                    resp_ack = 1'b1;
                    resp_rdata = r.rdata;
                    active = 1'b0;
                end else cnt++;
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                         input logic [4:0] rd, input int d, input logic [31:0] rdata);
        logic [31:0] ea, v, shifted;
        int sz, lat, c;
        logic illegal, mis;
        ea = base + off;
        sz = int'(f3) % 4;
        illegal = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (st && f3 > 3'd2);
        mis = (sz == 1 && (ea % 2) != 0) || (sz == 2 && (ea % 4) != 0);
        if (!ld && !st) lat = 1;
        else if (illegal || mis) begin
            exc_q.push_back('{illegal ? 2'b11 : (ld ? 2'b01 : 2'b10), ea});
            lat = 2;
        end else if (st) begin
            if (sz == 0)      mem_q.push_back('{ea & ~32'd3, 1'b1, 4'(1 << (ea % 4)), (sd & 32'hFF) * 32'h01010101});
            else if (sz == 1) mem_q.push_back('{ea & ~32'd3, 1'b1, 4'(3 << (2 * ((ea / 2) % 2))), (sd & 32'hFFFF) * 32'h00010001});
            else              mem_q.push_back('{ea & ~32'd3, 1'b1, 4'hF, sd});
            resp_q.push_back('{d, rdata});
            lat = d + 2;
        end else begin
            mem_q.push_back('{ea & ~32'd3, 1'b0, 4'h0, 32'd0});
            resp_q.push_back('{d, rdata});
            if (sz == 0) begin
                shifted = rdata >> (8 * (ea % 4));
                v = shifted & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 1) begin
                shifted = rdata >> (16 * ((ea / 2) % 2));
                v = shifted & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end else v = rdata;
            if (rd != 5'd0) wb_q.push_back('{rd, v});
            lat = d + 3;
        end
        bus.is_load = ld; bus.is_store = st; bus.funct3 = f3;
        bus.base = base; bus.offset = off; bus.store_data = sd; bus.rd_in = rd;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.base = $urandom; bus.offset = $urandom; bus.store_data = $urandom;
        c = 1;
        while (!bus.req_ready && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("latency", c, lat);
    endtask

    initial begin
        logic ld, st;
        logic [2:0] f3;
        logic [31:0] base, off;
        int sel;
        bus.req_valid = 0; bus.is_load = 0; bus.is_store = 0; bus.funct3 = 0;
        bus.base = 0; bus.offset = 0; bus.store_data = 0; bus.rd_in = 0;
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_bus", {bus.mem_addr[31:5] | bus.mem_wdata[31:5], bus.mem_we, bus.mem_wstrb}, 32'd0);
        check("rst_wb", {bus.wb_data[31:6], bus.wb_en, bus.wb_rd}, 32'd0);
        check("rst_exc", {bus.exc_addr[31:3], bus.exc_valid, bus.exc_cause}, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        issue(1, 0, 3'b010, 32'h1000, 32'h4, 0, 5'd5, 2, 32'hDEADBEEF);
        issue(1, 0, 3'b000, 32'h2000, 32'h3, 0, 5'd7, 0, 32'h80112233);
        issue(1, 0, 3'b100, 32'h2000, 32'h3, 0, 5'd8, 1, 32'h80112233);
        issue(0, 1, 3'b000, 32'h3000, 32'h1, 32'hAB, 5'd9, 0, 0);
        issue(0, 1, 3'b001, 32'h3000, 32'h2, 32'h1234, 5'd0, 1, 0);
        issue(1, 0, 3'b010, 32'h4000, 32'h2, 0, 5'd3, 0, 0);
        issue(0, 1, 3'b001, 32'h4000, 32'h1, 0, 5'd3, 0, 0);
        issue(1, 0, 3'b011, 32'h4000, 32'h0, 0, 5'd3, 0, 0);
        issue(1, 1, 3'b000, 32'h4000, 32'h0, 0, 5'd3, 0, 0);
        issue(1, 0, 3'b010, 32'hFFFFFFFC, 32'h8, 0, 5'd4, 0, 32'h0BADF00D);
        issue(1, 0, 3'b010, 32'h5000, 32'h0, 0, 5'd0, 1, 32'h12345678);
        issue(0, 0, 3'b010, 32'h5000, 32'h0, 0, 5'd6, 0, 0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 19);
            ld = (sel < 9) || (sel == 18);
            st = (sel >= 9);
            if (sel == 19) begin ld = 0; st = 0; end
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld) f3 = 3'($urandom_range(0, 4) < 3 ? $urandom_range(0, 2) : $urandom_range(4, 5));
            else f3 = 3'($urandom_range(0, 2));
            base = $urandom;
            if ($urandom_range(0, 1) == 0) base = base & ~32'd3;
            if ($urandom_range(0, 9) == 0) base = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            off = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 15)) - 32'd8;
            issue(ld, st, f3, base, off, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        // Reset while a load is waiting on memory.
        mem_q.push_back('{32'h6000, 1'b0, 4'h0, 32'd0});
        resp_q.push_back('{50, 32'hFFFFFFFF});
        bus.is_load = 1; bus.is_store = 0; bus.funct3 = 3'b010;
        bus.base = 32'h6000; bus.offset = 0; bus.rd_in = 5'd10;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        mem_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_ready", 32'(bus.req_ready), 32'd1);
            check("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
            check("late_ack_wb_en", 32'(bus.wb_en), 32'd0);
            @(posedge clk); #1;
        end

        issue(0, 1, 3'b010, 32'h7000, 32'h0, 32'hCAFEF00D, 5'd1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mem_q_left", mem_q.size(), 0);
        check("wb_q_left", wb_q.size(), 0);
        check("exc_q_left", exc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
